// File: rtl/fifo_16x8_wr_arb_ctrl_if.sv
// Signal bundle joining the FIFO controller to its two write requesters, the consumer and the 16x8 memory.
// almost_full/almost_empty are present only when FIFO_CTRL_ALMOST_EN is defined.
interface fifo_16x8_wr_arb_ctrl_if #(
    parameter int unsigned AW = 4,
    parameter int unsigned DW = 8
);
    logic          req0_valid;
    logic [DW-1:0] req0_data;
    logic          req0_ready;
    logic          req1_valid;
    logic [DW-1:0] req1_data;
    logic          req1_ready;
    logic          rd_req;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [DW-1:0] mem_din;
    logic          mem_re;
    logic [AW-1:0] mem_raddr;
    logic [DW-1:0] mem_dout;
    logic [AW:0]   count;
    logic          full;
    logic          empty;
    logic          rd_underflow;
`ifdef FIFO_CTRL_ALMOST_EN
    logic          almost_full;
    logic          almost_empty;
`endif

    modport slave (
        input  req0_valid, req0_data, req1_valid, req1_data, rd_req, mem_dout,
        output req0_ready, req1_ready, rd_valid, rd_data,
        output mem_we, mem_waddr, mem_din, mem_re, mem_raddr,
`ifdef FIFO_CTRL_ALMOST_EN
        output almost_full, almost_empty,
`endif
        output count, full, empty, rd_underflow
    );

    modport master (
        output req0_valid, req0_data, req1_valid, req1_data, rd_req, mem_dout,
        input  req0_ready, req1_ready, rd_valid, rd_data,
        input  mem_we, mem_waddr, mem_din, mem_re, mem_raddr,
`ifdef FIFO_CTRL_ALMOST_EN
        input  almost_full, almost_empty,
`endif
        input  count, full, empty, rd_underflow
    );
endinterface

// File: rtl/fifo_16x8_wr_arb_ctrl.sv
// FIFO sequencer for a 16x8 addressed memory: round-robin arbitration of two writers, pointer/count ownership, pop path.
// Optional macro FIFO_CTRL_ALMOST_EN adds AF_THRESH/AE_THRESH and almost_full/almost_empty.
module fifo_16x8_wr_arb_ctrl #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4,
    parameter int unsigned DW    = 8
`ifdef FIFO_CTRL_ALMOST_EN
    ,
    parameter int unsigned AF_THRESH = 14,
    parameter int unsigned AE_THRESH = 2
`endif
) (
    input logic                    clk,
    input logic                    rst,
    fifo_16x8_wr_arb_ctrl_if.slave bus
);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          prio_q, prio_d;      // 0: req0 wins a tie, 1: req1 wins
    logic          rd_valid_q, rd_valid_d;
    logic          underflow_q, underflow_d;
    logic          full_c, empty_c, grant0_c, grant1_c, wr_en_c, rd_en_c;

    // Grant and pop acceptance depend only on the current count, never on pointer equality.
    always_comb begin
        full_c   = (count_q == FULL_CNT);
        empty_c  = (count_q == '0);
        grant0_c = !full_c && bus.req0_valid && (!bus.req1_valid || !prio_q);
        grant1_c = !full_c && bus.req1_valid && (!bus.req0_valid ||  prio_q);
        wr_en_c  = grant0_c || grant1_c;
        rd_en_c  = bus.rd_req && !empty_c;
    end

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        prio_d      = prio_q;
        rd_valid_d  = rd_en_c;
        underflow_d = underflow_q || (bus.rd_req && empty_c);
        if (wr_en_c) wr_ptr_d = wr_ptr_q + AW'(1);
        if (rd_en_c) rd_ptr_d = rd_ptr_q + AW'(1);
        case ({wr_en_c, rd_en_c})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        if (grant0_c)      prio_d = 1'b1;
        else if (grant1_c) prio_d = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            prio_q      <= 1'b0;
            rd_valid_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            prio_q      <= prio_d;
            rd_valid_q  <= rd_valid_d;
            underflow_q <= underflow_d;
        end
    end

    assign bus.req0_ready   = grant0_c;
    assign bus.req1_ready   = grant1_c;
    assign bus.mem_we       = wr_en_c;
    assign bus.mem_waddr    = wr_ptr_q;
    assign bus.mem_din      = grant1_c ? bus.req1_data : bus.req0_data;
    assign bus.mem_re       = rd_en_c;
    assign bus.mem_raddr    = rd_ptr_q;
    assign bus.rd_valid     = rd_valid_q;
    assign bus.rd_data      = bus.mem_dout;
    assign bus.count        = count_q;
    assign bus.full         = full_c;
    assign bus.empty        = empty_c;
    assign bus.rd_underflow = underflow_q;
`ifdef FIFO_CTRL_ALMOST_EN
    assign bus.almost_full  = (count_q >= CW'(AF_THRESH));
    assign bus.almost_empty = (count_q <= CW'(AE_THRESH));
`endif
endmodule

// File: tb/tb_fifo_16x8_wr_arb_ctrl.sv
// Directed bench for fifo_16x8_wr_arb_ctrl with a behavioural 16x8 memory (1-cycle registered read).
module tb_fifo_16x8_wr_arb_ctrl;
    logic clk;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    fifo_16x8_wr_arb_ctrl_if #(.AW(4), .DW(8)) bus ();

    fifo_16x8_wr_arb_ctrl #(.DEPTH(16), .AW(4), .DW(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    logic [7:0] mem_q [16];
    logic [7:0] dout_q;
    always @(posedge clk) begin
        if (bus.mem_we) mem_q[bus.mem_waddr] <= bus.mem_din;
        if (bus.mem_re) dout_q <= mem_q[bus.mem_raddr];
    end
    assign bus.mem_dout = dout_q;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.rd_req     = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic push0(input logic [7:0] d);
        bus.req0_valid = 1'b1;
        bus.req0_data  = d;
        tick();
        bus.req0_valid = 1'b0;
    endtask

    initial begin
        logic [7:0] e;
        rst = 1'b1;
        bus.req0_data = '0;
        bus.req1_data = '0;
        idle();

        // Reset state
        do_reset();
        chk("rst_count", 32'(bus.count), 0);
        chk("rst_empty", 32'(bus.empty), 1);
        chk("rst_full", 32'(bus.full), 0);
        chk("rst_rd_valid", 32'(bus.rd_valid), 0);
        chk("rst_underflow", 32'(bus.rd_underflow), 0);
        chk("rst_mem_we", 32'(bus.mem_we), 0);
        chk("rst_mem_re", 32'(bus.mem_re), 0);
        chk("rst_waddr", 32'(bus.mem_waddr), 0);
        chk("rst_raddr", 32'(bus.mem_raddr), 0);
`ifdef FIFO_CTRL_ALMOST_EN
        chk("rst_almost_full", 32'(bus.almost_full), 0);
        chk("rst_almost_empty", 32'(bus.almost_empty), 1);
`endif

        // Fill from req0 only, then drain in order
        for (int i = 0; i < 16; i++) begin
            bus.req0_valid = 1'b1;
            bus.req0_data  = 8'(i);
            #1;
            chk("fill_ready", 32'(bus.req0_ready), 1);
            chk("fill_waddr", 32'(bus.mem_waddr), 32'(i));
            chk("fill_din", 32'(bus.mem_din), 32'(i));
            tick();
        end
        chk("fill_count", 32'(bus.count), 16);
        chk("fill_full", 32'(bus.full), 1);
        chk("fill_empty", 32'(bus.empty), 0);
        bus.req0_data = 8'h10;
        #1;
        chk("fill17_ready", 32'(bus.req0_ready), 0);
        chk("fill17_we", 32'(bus.mem_we), 0);
        tick();
        chk("fill17_count", 32'(bus.count), 16);
        bus.req0_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            bus.rd_req = 1'b1;
            #1;
            chk("drain_re", 32'(bus.mem_re), 1);
            chk("drain_raddr", 32'(bus.mem_raddr), 32'(i));
            tick();
            chk("drain_valid", 32'(bus.rd_valid), 1);
            chk("drain_data", 32'(bus.rd_data), 32'(i));
        end
        bus.rd_req = 1'b0;
        chk("drain_count", 32'(bus.count), 0);
        chk("drain_empty", 32'(bus.empty), 1);
        tick();
        chk("drain_valid_off", 32'(bus.rd_valid), 0);

        // Contention: both requesters valid every cycle from reset
        do_reset();
        begin
            int n0 = 0;
            int n1 = 0;
            bus.req0_valid = 1'b1;
            bus.req1_valid = 1'b1;
            for (int i = 0; i < 8; i++) begin
                bus.req0_data = 8'(8'hA0 + n0);
                bus.req1_data = 8'(8'hB0 + n1);
                #1;
                e = (i % 2 == 0) ? 8'(8'hA0 + i / 2) : 8'(8'hB0 + i / 2);
                chk("arb_r0_ready", 32'(bus.req0_ready), (i % 2 == 0) ? 1 : 0);
                chk("arb_r1_ready", 32'(bus.req1_ready), (i % 2 == 0) ? 0 : 1);
                chk("arb_din", 32'(bus.mem_din), 32'(e));
                if (bus.req0_ready) n0++;
                if (bus.req1_ready) n1++;
                tick();
            end
        end
        idle();
        chk("arb_count", 32'(bus.count), 8);
        for (int i = 0; i < 8; i++) begin
            bus.rd_req = 1'b1;
            tick();
            e = (i % 2 == 0) ? 8'(8'hA0 + i / 2) : 8'(8'hB0 + i / 2);
            chk("arb_pop_data", 32'(bus.rd_data), 32'(e));
        end
        idle();

        // Simultaneous push and pop at count 5
        do_reset();
        for (int i = 0; i < 5; i++) push0(8'(8'h10 + i));
        chk("pp_count_pre", 32'(bus.count), 5);
        bus.req1_valid = 1'b1;
        bus.req1_data  = 8'h55;
        bus.rd_req     = 1'b1;
        #1;
        chk("pp_r1_ready", 32'(bus.req1_ready), 1);
        chk("pp_waddr", 32'(bus.mem_waddr), 5);
        chk("pp_din", 32'(bus.mem_din), 32'h55);
        chk("pp_re", 32'(bus.mem_re), 1);
        chk("pp_raddr", 32'(bus.mem_raddr), 0);
        tick();
        idle();
        chk("pp_count", 32'(bus.count), 5);
        chk("pp_rd_valid", 32'(bus.rd_valid), 1);
        chk("pp_rd_data", 32'(bus.rd_data), 32'h10);
        bus.rd_req = 1'b1;
        #1;
        chk("pp_raddr_adv", 32'(bus.mem_raddr), 1);
        chk("pp_waddr_adv", 32'(bus.mem_waddr), 6);
        tick();
        chk("pp_rd_data2", 32'(bus.rd_data), 32'h11);
        idle();

        // Underflow is sticky until reset
        do_reset();
        bus.rd_req = 1'b1;
        #1;
        chk("uf_re", 32'(bus.mem_re), 0);
        tick();
        bus.rd_req = 1'b0;
        chk("uf_flag", 32'(bus.rd_underflow), 1);
        chk("uf_rd_valid", 32'(bus.rd_valid), 0);
        chk("uf_raddr", 32'(bus.mem_raddr), 0);
        for (int i = 0; i < 10; i++) tick();
        chk("uf_held", 32'(bus.rd_underflow), 1);
        do_reset();
        chk("uf_cleared", 32'(bus.rd_underflow), 0);

        // Wrap-around with count held at 2
        push0(8'd0);
        push0(8'd1);
        for (int i = 0; i < 38; i++) begin
            bus.req0_valid = 1'b1;
            bus.req0_data  = 8'(i + 2);
            bus.rd_req     = 1'b1;
            #1;
            chk("wrap_waddr", 32'(bus.mem_waddr), 32'((i + 2) % 16));
            chk("wrap_raddr", 32'(bus.mem_raddr), 32'(i % 16));
            tick();
            chk("wrap_rdata", 32'(bus.rd_data), 32'(i));
            chk("wrap_count", 32'(bus.count), 2);
        end
        idle();
        for (int i = 38; i < 40; i++) begin
            bus.rd_req = 1'b1;
            tick();
            chk("wrap_tail", 32'(bus.rd_data), 32'(i));
        end
        idle();
        chk("wrap_empty", 32'(bus.empty), 1);

        // Full with a pop in the same cycle: write still rejected
        for (int i = 0; i < 16; i++) push0(8'(8'h60 + i));
        chk("fp_full", 32'(bus.full), 1);
        bus.req0_valid = 1'b1;
        bus.req0_data  = 8'hEE;
        bus.rd_req     = 1'b1;
        #1;
        chk("fp_ready", 32'(bus.req0_ready), 0);
        chk("fp_we", 32'(bus.mem_we), 0);
        chk("fp_re", 32'(bus.mem_re), 1);
        tick();
        idle();
        chk("fp_count", 32'(bus.count), 15);
        chk("fp_full_off", 32'(bus.full), 0);
        chk("fp_rd_data", 32'(bus.rd_data), 32'h60);

        // Reset mid-stream: count 7 and a pop in flight, priority left at req1
        do_reset();
        for (int i = 0; i < 9; i++) push0(8'(8'h30 + i));
        bus.rd_req = 1'b1;
        tick();
        tick();
        bus.rd_req = 1'b0;
        chk("mid_count_pre", 32'(bus.count), 7);
        chk("mid_valid_pre", 32'(bus.rd_valid), 1);
        rst = 1'b1;
        #1;
        chk("mid_count", 32'(bus.count), 0);
        chk("mid_empty", 32'(bus.empty), 1);
        chk("mid_rd_valid", 32'(bus.rd_valid), 0);
        tick();
        rst = 1'b0;
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        #1;
        chk("mid_prio_r0", 32'(bus.req0_ready), 1);
        chk("mid_prio_r1", 32'(bus.req1_ready), 0);
        idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fifo_16x8_wr_arb_ctrl.md
Name: fifo_16x8_wr_arb_ctrl

Overview:
Controller that sequences the 16-entry x 8-bit addressed memory (we/w_addr/din, re/r_addr/dout) as a true FIFO. It arbitrates two write requesters round-robin, owns the write/read pointers and occupancy count, and drives all memory control ports. The memory has a 1-cycle registered read; this block returns read data with a matching valid strobe.

Parameters:
DEPTH, 16, number of memory entries; must be a power of 2.
AW, 4, pointer/address width, log2(DEPTH).
DW, 8, data width.

Ports:
clk  input  1  system clock; all state on posedge.
rst  input  1  asynchronous, active-high reset.
req0_valid  input  1  requester 0 has write data.
req0_data  input  DW  requester 0 write data.
req0_ready  output  1  requester 0 write accepted this cycle.
req1_valid  input  1  requester 1 has write data.
req1_data  input  DW  requester 1 write data.
req1_ready  output  1  requester 1 write accepted this cycle.
rd_req  input  1  consumer requests one pop.
rd_valid  output  1  rd_data valid; asserted the cycle after an accepted pop.
rd_data  output  DW  pop data (mem_dout passthrough).
mem_we  output  1  memory write enable.
mem_waddr  output  AW  memory write address.
mem_din  output  DW  memory write data.
mem_re  output  1  memory read enable.
mem_raddr  output  AW  memory read address.
mem_dout  input  DW  memory read data, valid 1 cycle after mem_re.
count  output  AW+1  occupancy, 0..DEPTH.
full  output  1  count == DEPTH.
empty  output  1  count == 0.
rd_underflow  output  1  sticky: rd_req seen while empty.

Behaviour:
- Reset (async, rst=1): wr_ptr=0, rd_ptr=0, count=0, rd_valid=0, rd_underflow=0, priority=req0; full=0, empty=1; mem_we=0, mem_re=0, addresses 0. Memory contents not cleared.
- Write arbitration (combinational, from current state): no grant if full. Otherwise, if only one requester is valid it is granted; if both are valid, the requester holding priority is granted. Ready is asserted only to the granted requester, and ready implies valid.
- Priority register: after a grant to reqN, priority moves to the other requester. No grant -> priority unchanged.
- Accepted write (same cycle): mem_we=1, mem_waddr=wr_ptr, mem_din=granted data. At posedge, wr_ptr increments modulo DEPTH (15 wraps to 0).
- Pop: accepted when rd_req && !empty. Same cycle: mem_re=1, mem_raddr=rd_ptr. At posedge, rd_ptr increments modulo DEPTH and rd_valid is registered to 1. Next cycle, rd_data=mem_dout. Otherwise rd_valid=0 at that posedge.
- rd_req && empty: no mem_re and no pointer change; rd_underflow is set and stays set until rst.
- count: +1 on write only, -1 on pop only, unchanged when both occur in the same cycle.
- Full with pop in the same cycle: the write is still rejected (no same-cycle refill).
- Empty with write in the same cycle: the pop is still rejected (no bypass).
- Back-to-back pops are allowed every cycle; rd_valid stays high continuously.
- count never exceeds DEPTH and never goes below 0; pointer equality alone is never used to derive full/empty.
- Reset mid-operation: any in-flight read is discarded (rd_valid=0 immediately); all state returns to reset values.

Optional Feature:
Macro FIFO_CTRL_ALMOST_EN.
- Defined: adds parameters AF_THRESH (default 14) and AE_THRESH (default 2), plus outputs almost_full (count >= AF_THRESH) and almost_empty (count <= AE_THRESH). Both are combinational from count; reset values are almost_full=0, almost_empty=1.
- Undefined: these ports and parameters do not exist; all other behaviour is identical.

Test Plan:
- Fill: req0 only writes 0x00..0x0F. Expect mem_waddr 0..15, full=1 and count=16 after the 16th write, req0_ready=0 on a 17th attempt. Then pop 16 times: rd_data 0x00..0x0F in order, empty=1.
- Contention: both requesters valid continuously (req0 0xA0.., req1 0xB0..) from reset. Expect accepted order A0,B0,A1,B1,... and popped data in the same order.
- Simultaneous push+pop at count=5: count stays 5, both pointers advance, rd_valid=1 next cycle with the oldest data.
- Underflow: rd_req while empty. Expect mem_re=0 and rd_underflow=1 held through 10 idle cycles, cleared only by rst.
- Wrap-around: interleave 40 writes and pops while keeping count between 1 and 3. Expect pointers to wrap 15->0 with data order preserved. Full+pop while full: write rejected, count drops to 15.
- Reset mid-stream: assert rst with count=7 and a pop in flight. Expect immediate count=0, empty=1, rd_valid=0, priority=req0.
